// File: rtl/timer_multich_if.sv
// Control/status bundle for timer_multich: one tick strobe, per-channel start/stop/mode/limit in,
// per-channel running/flag/count out. Counts and limits are packed channel k at [k*WIDTH +: WIDTH].
interface timer_multich_if #(
  parameter int WIDTH  = 28,
  parameter int NUM_CH = 4
);
  logic                      tick_i;
  logic [NUM_CH-1:0]         start_i;
  logic [NUM_CH-1:0]         stop_i;
  logic [NUM_CH-1:0]         mode_i;
  logic [NUM_CH*WIDTH-1:0]   limit_i;
  logic [NUM_CH-1:0]         running_o;
  logic [NUM_CH-1:0]         flag_o;
  logic [NUM_CH*WIDTH-1:0]   count_o;
  logic                      any_flag_o;

  modport master (
    output tick_i, start_i, stop_i, mode_i, limit_i,
    input  running_o, flag_o, count_o, any_flag_o
  );

  modport slave (
    input  tick_i, start_i, stop_i, mode_i, limit_i,
    output running_o, flag_o, count_o, any_flag_o
  );
endinterface

// File: rtl/timer_multich.sv
// NUM_CH independent tick-gated up-counters with latched limit, periodic/one-shot mode and terminal pulse.
// Outputs registered one clock after the controlling edge (any_flag_o is a pure OR); no backpressure.
module timer_multich #(
  parameter int WIDTH  = 28,
  parameter int NUM_CH = 4
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  timer_multich_if.slave bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e            state_q [NUM_CH];
  state_e            state_d [NUM_CH];
  logic [WIDTH-1:0]  count_q [NUM_CH];
  logic [WIDTH-1:0]  count_d [NUM_CH];
  logic [WIDTH-1:0]  limit_q [NUM_CH];
  logic [WIDTH-1:0]  limit_d [NUM_CH];
  logic [NUM_CH-1:0] mode_q;
  logic [NUM_CH-1:0] mode_d;
  logic [NUM_CH-1:0] flag_q;
  logic [NUM_CH-1:0] flag_d;

  logic [NUM_CH-1:0]       running;
  logic [NUM_CH*WIDTH-1:0] count_flat;

  // Per channel: stop beats start beats counting; the terminal compare uses the latched limit only.
  always_comb begin
    mode_d = mode_q;
    flag_d = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      state_d[k] = state_q[k];
      count_d[k] = count_q[k];
      limit_d[k] = limit_q[k];
      if (bus.stop_i[k]) begin
        state_d[k] = ST_IDLE;
      end else if (bus.start_i[k]) begin
        limit_d[k] = bus.limit_i[k*WIDTH +: WIDTH];
        mode_d[k]  = bus.mode_i[k];
        count_d[k] = '0;
        state_d[k] = ST_RUN;
      end else if (state_q[k] == ST_RUN && bus.tick_i) begin
        if (count_q[k] == limit_q[k]) begin
          flag_d[k] = 1'b1;
          // One-shot parks at the limit; periodic wraps without ever exceeding it.
          if (mode_q[k]) begin
            state_d[k] = ST_IDLE;
          end else begin
            count_d[k] = '0;
          end
        end else begin
          count_d[k] = count_q[k] + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < NUM_CH; k++) begin
        state_q[k] <= ST_IDLE;
        count_q[k] <= '0;
        limit_q[k] <= '0;
      end
      mode_q <= '0;
      flag_q <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        state_q[k] <= state_d[k];
        count_q[k] <= count_d[k];
        limit_q[k] <= limit_d[k];
      end
      mode_q <= mode_d;
      flag_q <= flag_d;
    end
  end

  always_comb begin
    running    = '0;
    count_flat = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      running[k]                 = (state_q[k] == ST_RUN);
      count_flat[k*WIDTH +: WIDTH] = count_q[k];
    end
  end

  assign bus.running_o  = running;
  assign bus.count_o    = count_flat;
  assign bus.flag_o     = flag_q;
  assign bus.any_flag_o = |flag_q;

endmodule

// File: tb/tb_timer_multich.sv
// Randomized and directed check of timer_multich against a tick-count reference model.
module tb_timer_multich;
  localparam int W  = 28;
  localparam int N  = 4;
  localparam int W4 = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  timer_multich_if #(.WIDTH(W),  .NUM_CH(N)) bus  ();
  timer_multich_if #(.WIDTH(W4), .NUM_CH(1)) bus4 ();

  timer_multich #(.WIDTH(W),  .NUM_CH(N)) dut  (.clk_i(clk), .rst_n_i(rst_n), .bus(bus));
  timer_multich #(.WIDTH(W4), .NUM_CH(1)) dut4 (.clk_i(clk), .rst_n_i(rst_n), .bus(bus4));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: each channel remembers how many ticks it has accepted since its last start.
  // Count and flag follow from that tick total and the latched limit by plain arithmetic.
  bit          m_run   [N];
  longint      m_ticks [N];
  longint      m_lim   [N];
  bit          m_mode  [N];
  bit [N-1:0]  m_flag;

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_run[k] = 0; m_ticks[k] = 0; m_lim[k] = 0; m_mode[k] = 0;
    end
    m_flag = '0;
  endtask

  function automatic longint model_count(int k);
    if (m_mode[k]) return (m_ticks[k] > m_lim[k]) ? m_lim[k] : m_ticks[k];
    return m_ticks[k] % (m_lim[k] + 1);
  endfunction

  task automatic model_step();
    m_flag = '0;
    for (int k = 0; k < N; k++) begin
      if (bus.stop_i[k]) begin
        m_run[k] = 0;
      end else if (bus.start_i[k]) begin
        m_lim[k]   = longint'(bus.limit_i[k*W +: W]);
        m_mode[k]  = bus.mode_i[k];
        m_ticks[k] = 0;
        m_run[k]   = 1;
      end else if (m_run[k] && bus.tick_i) begin
        m_ticks[k]++;
        if (m_ticks[k] % (m_lim[k] + 1) == 0) m_flag[k] = 1;
        if (m_mode[k] && m_ticks[k] == m_lim[k] + 1) m_run[k] = 0;
      end
    end
  endtask

  task automatic check_all(input string where);
    for (int k = 0; k < N; k++) begin
      check_eq($sformatf("%s cnt%0d", where, k), 64'(bus.count_o[k*W +: W]), 64'(model_count(k)));
      check_eq($sformatf("%s run%0d", where, k), 64'(bus.running_o[k]), 64'(m_run[k]));
    end
    check_eq({where, " flag"}, 64'(bus.flag_o), 64'(m_flag));
    check_eq({where, " any_flag"}, 64'(bus.any_flag_o), 64'(|m_flag));
  endtask

  task automatic cycle(input string where);
    @(posedge clk);
    model_step();
    #1;
    check_all(where);
  endtask

  task automatic set_lim(input int k, input logic [W-1:0] v);
    logic [N*W-1:0] lv;
    lv = bus.limit_i;
    lv[k*W +: W] = v;
    bus.limit_i = lv;
  endtask

  initial begin
    rst_n = 1'b1;
    bus.tick_i = 0; bus.start_i = '0; bus.stop_i = '0; bus.mode_i = '0; bus.limit_i = '0;
    bus4.tick_i = 0; bus4.start_i = '0; bus4.stop_i = '0; bus4.mode_i = '0; bus4.limit_i = '0;
    model_reset();
    #2 rst_n = 1'b0;
    #2 check_all("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Periodic ch0, limit 3, continuous ticks.
    bus.tick_i = 1; bus.start_i = 4'b0001; set_lim(0, 3);
    cycle("per_start");
    bus.start_i = '0;
    repeat (10) cycle("per");

    // One-shot ch1, limit 2, tick on every third clock.
    bus.stop_i = 4'b0001; bus.start_i = 4'b0010; bus.mode_i = 4'b0010; set_lim(1, 2);
    cycle("os_start");
    bus.stop_i = '0; bus.start_i = '0;
    for (int i = 0; i < 15; i++) begin
      bus.tick_i = (i % 3 == 0);
      cycle("oneshot");
    end

    // ch2: count to 7, start+stop together, then restart with limit 1.
    bus.tick_i = 1; bus.mode_i = '0; bus.start_i = 4'b0100; set_lim(2, 10);
    cycle("c2_start");
    bus.start_i = '0;
    repeat (7) cycle("c2_run");
    bus.start_i = 4'b0100; bus.stop_i = 4'b0100; set_lim(2, 1);
    cycle("c2_both");
    bus.stop_i = '0;
    cycle("c2_restart");
    bus.start_i = '0;
    repeat (6) cycle("c2_lim1");

    // ch3 limit 0 periodic.
    bus.start_i = 4'b1000; set_lim(3, 0);
    cycle("c3_start");
    bus.start_i = '0;
    repeat (5) cycle("c3_lim0");

    // ch0+ch1 limit 1 together; limit_i changes mid-run must not matter.
    bus.stop_i = 4'b1111;
    cycle("stop_all");
    bus.stop_i = '0; bus.start_i = 4'b0011; set_lim(0, 1); set_lim(1, 1);
    cycle("coin_start");
    bus.start_i = '0;
    repeat (5) cycle("coin");
    set_lim(0, 3); set_lim(1, 3);
    repeat (5) cycle("coin_chg");

    // Reset asserted mid-count between edges.
    bus.stop_i = 4'b1111;
    cycle("stop_all2");
    bus.stop_i = '0; bus.start_i = 4'b0001; set_lim(0, 5);
    cycle("rst_start");
    bus.start_i = '0;
    repeat (3) cycle("rst_cnt");
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all("rst_mid");
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) cycle("rst_after");

    // WIDTH=4 instance at full-scale limit.
    bus4.tick_i = 1; bus4.start_i = 1'b1; bus4.limit_i = 4'hF;
    cycle("w4_start");
    check_eq("w4 cnt start", 64'(bus4.count_o), 64'd0);
    bus4.start_i = 1'b0;
    for (int j = 1; j <= 34; j++) begin
      cycle("w4_main");
      check_eq($sformatf("w4 cnt j=%0d", j), 64'(bus4.count_o), 64'(j % 16));
      check_eq($sformatf("w4 flag j=%0d", j), 64'(bus4.flag_o), 64'(j % 16 == 0));
      check_eq($sformatf("w4 run j=%0d", j), 64'(bus4.running_o), 64'd1);
    end

    // Random traffic on all channels.
    for (int i = 0; i < 2000; i++) begin
      logic [N-1:0] st, sp, md;
      st = '0; sp = '0; md = '0;
      for (int k = 0; k < N; k++) begin
        st[k] = ($urandom_range(0, 15) == 0);
        sp[k] = ($urandom_range(0, 31) == 0);
        md[k] = $urandom_range(0, 1) == 1;
        case ($urandom_range(0, 9))
          0:       set_lim(k, {W{1'b1}});
          1:       set_lim(k, W'($urandom));
          default: set_lim(k, W'($urandom_range(0, 7)));
        endcase
      end
      bus.start_i = st; bus.stop_i = sp; bus.mode_i = md;
      bus.tick_i  = ($urandom_range(0, 3) != 0);
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/timer_multich.md
Name: timer_multich

Overview:
- Parametrised multi-channel successor to the single free-running enable-clocked counter.
- NUM_CH independent up-counters share one system clock and one count-enable strobe.
- Each channel has its own latched terminal value, periodic or one-shot mode, start/stop control, a terminal-count pulse and a visible count.
- Used as the shared timebase and timeout block for display-refresh, debounce and blink logic.

Parameters:
- WIDTH, 28, counter and limit width in bits (≥2).
- NUM_CH, 4, number of independent channels (≥1).

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- tick_i  in  1  global count-enable strobe; counting advances only on clk_i edges where tick_i=1.
- start_i  in  NUM_CH  per-channel start/restart request, level-sampled each clock.
- stop_i  in  NUM_CH  per-channel stop request.
- mode_i  in  NUM_CH  0=periodic, 1=one-shot; sampled on accepted start.
- limit_i  in  NUM_CH*WIDTH  terminal value per channel, channel k at [k*WIDTH +: WIDTH]; sampled on accepted start.
- running_o  out  NUM_CH  channel k in RUN state.
- flag_o  out  NUM_CH  one-clock terminal-count pulse per channel.
- count_o  out  NUM_CH*WIDTH  current count per channel, same packing as limit_i.
- any_flag_o  out  1  OR of flag_o.

Behaviour:
- Reset (rst_n_i=0, asynchronous, takes effect immediately and overrides everything): all channels go IDLE. Outputs and internal state:
  - count_o=0, flag_o=0, running_o=0, any_flag_o=0.
  - Latched limits=0, latched modes=0.
- All outputs are registered except any_flag_o, which is a combinational OR of registered flag_o.
- Per-channel FSM, two states: IDLE and RUN.
- Priority each clock, per channel: stop_i > start_i > counting.
- stop_i=1, any state:
  - Next state IDLE.
  - count held at its current value.
  - flag_o=0 next cycle, even if the terminal was reached the same cycle.
- start_i=1 with stop_i=0, any state (restart allowed while RUN):
  - Latch limit_i and mode_i.
  - count←0, next state RUN, flag_o←0.
  - tick_i is ignored on the start cycle.
- RUN, no start/stop, tick_i=1:
  - If count≠limit: count←count+1, flag_o←0.
  - If count==limit: flag_o←1 for exactly one cycle, then:
    - periodic: count←0, stay RUN.
    - one-shot: count held at limit, go IDLE.
- RUN, no start/stop, tick_i=0: count held, flag_o←0.
- IDLE, no start: count held, flag_o←0; ticks have no effect.
- Period: with tick_i=1 every clock, a periodic channel pulses every limit+1 ticks.
  - First flag is registered on the clock edge of the (limit+1)-th tick after the start cycle.
  - flag_o is visible the cycle after that edge's tick was presented.
- limit=0:
  - periodic: flag on every tick.
  - one-shot: flag on the first tick, then IDLE.
- Wrap-around: count never exceeds limit. With limit=2^WIDTH−1 the count reaches all-ones, then returns to 0 via the terminal rule. There is no arithmetic overflow path.
- Changing limit_i or mode_i while RUN has no effect until the next accepted start.
- Channels are fully independent. Simultaneous flags on several channels are all reported in the same cycle.

Test Plan:
- Reset mid-count: ch0 periodic limit=5 running at count 3, assert rst_n_i asynchronously between edges -> count_o, flag_o, running_o become 0 immediately, before the next edge; after release, no counting without a new start.
- Periodic: ch0 start, limit=3, mode=0, tick_i=1 continuously -> count_o sequence 0,1,2,3,0,1,…; flag_o[0] high one cycle after each count=3 tick; period 4 clocks; running_o[0] stays 1.
- One-shot with gated ticks: ch1 limit=2, mode=1, tick_i=1 every third clock -> count 0,1,2 advances only on tick clocks; single flag_o[1] pulse; then running_o[1]=0, count_o held at 2; further ticks change nothing.
- Stop/start conflicts:
  - ch2 running, start_i and stop_i both high -> channel IDLE, count held.
  - Start alone while at count 7 with new limit=1 -> count 0, flags every 2 ticks.
- Edge limits: ch3 limit=0 periodic -> flag_o[3] every tick. WIDTH=4 instance with limit=15 -> counts to 15, flags, returns to 0.
- Multi-channel coincidence: ch0 and ch1 periodic limit=1 started the same cycle -> flag_o=4'b0011 simultaneously, any_flag_o=1 on those cycles only; limit_i changed mid-run -> period unchanged until restart.
